// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32I retire stage: major opcodes used by the
//   writeback path, load funct3 encodings, the writeback FSM state type and a
//   helper that extracts and extends load data from an aligned memory word.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  // Picks the byte/half addressed by off out of an aligned word and extends it
  // as funct3 requests. Any funct3 that is not a byte/half load returns the
  // whole word. Halves use off[1] only; off[0] is ignored for them.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] data);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    case (off)
      2'b00:   byte_sel = data[7:0];
      2'b01:   byte_sel = data[15:8];
      2'b10:   byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = off[1] ? data[31:16] : data[15:0];
    case (f3)
      F3_LB:   res = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  res = {24'h0, byte_sel};
      F3_LH:   res = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  res = {16'h0, half_sel};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// -----------------------------------------------------------------------------
// regfile_32x32
//   Integer register file: two asynchronous read ports, one synchronous write
//   port. x0 is hardwired to zero (writes dropped, reads return 0).
//   Optional feature macro: FORWARD_EN -- when defined, a read port whose index
//   matches the register being written this cycle (index != 0) returns the
//   write data combinationally instead of the stored value.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset (clears all regs)
//   we, waddr, wdata   write port, committed at the rising edge
//   rs1_addr, rs1d     read port 1
//   rs2_addr, rs2d     read port 2
// -----------------------------------------------------------------------------
module regfile_32x32 #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1d,
  output logic [XLEN-1:0] rs2d
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // NOTE: every variable assigned in always_comb gets a default first
  // (here the whole array copies the current state) so no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // NOTE: the array is reset on purpose -- architectural state must read 0
  // after reset -- so it builds as flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge input regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rs1d = '0;
    if (rs1_addr != '0) begin
      rs1d = regs_q[rs1_addr];
`ifdef FORWARD_EN
      if (we && (waddr == rs1_addr)) begin
        rs1d = wdata;
      end
`endif
    end
  end

  always_comb begin
    rs2d = '0;
    if (rs2_addr != '0) begin
      rs2d = regs_q[rs2_addr];
`ifdef FORWARD_EN
      if (we && (waddr == rs2_addr)) begin
        rs2d = wdata;
      end
`endif
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//   Retire side of the single-issue RV32I datapath. Selects the rd value from
//   the ALU result, pc+4 or extended load data and writes it into the owned
//   32x32 register file. A LOAD parks the FSM in WAIT_LOAD (wb_ready low)
//   until mem_rvalid delivers the word. retire pulses one cycle after each
//   retirement (after the load write for a LOAD).
//   Optional feature macro: FORWARD_EN (write-to-read bypass in regfile_32x32).
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   wb_valid / wb_ready      retire handshake; transfer = wb_valid & wb_ready
//   wb_opcode, wb_funct3     decoded opcode and funct3 (load width/sign)
//   wb_rd                    destination register
//   alu_res                  ALU result; load address for LOAD
//   wb_pc                    PC of the retiring instruction
//   mem_rvalid, mem_rdata    load data return (one-cycle pulse, aligned word)
//   rs1_addr/rs1d, rs2_addr/rs2d  combinational register read ports
//   retire                   registered retirement pulse
// -----------------------------------------------------------------------------
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [6:0]               wb_opcode,
  input  logic [2:0]               wb_funct3,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          alu_res,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic                     mem_rvalid,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1d,
  output logic [XLEN-1:0]          rs2d,
  output logic                     retire
);

  localparam int AW = $clog2(NREGS);

  wb_state_t       state_q, state_d;
  logic [AW-1:0]   ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            retire_q, retire_d;

  logic            transfer;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  assign wb_ready = (state_q == IDLE);
  assign transfer = wb_valid & wb_ready;
  assign retire   = retire_q;

  always_comb begin
    state_d  = state_q;
    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = wb_rd;
    rf_wdata = alu_res;

    case (state_q)
      IDLE: begin
        // mem_rvalid is deliberately ignored here: no load is outstanding.
        if (transfer) begin
          case (wb_opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
              rf_we    = 1'b1;
              retire_d = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
              rf_we    = 1'b1;
              rf_wdata = wb_pc + XLEN'(4);
              retire_d = 1'b1;
            end
            OPC_LOAD: begin
              // Only the pieces needed to finish the load later are kept;
              // the word arrives aligned, so addr[1:0] is all of the address.
              ld_rd_d  = wb_rd;
              ld_f3_d  = wb_funct3;
              ld_off_d = alu_res[1:0];
              state_d  = WAIT_LOAD;
            end
            default: begin
              // STORE, BRANCH, SYSTEM and illegal opcodes retire without a write.
              retire_d = 1'b1;
            end
          endcase
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          rf_we    = 1'b1;
          rf_waddr = ld_rd_q;
          rf_wdata = load_extract(ld_f3_q, ld_off_q, mem_rdata);
          retire_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ld_rd_q  <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_rd_q  <= ld_rd_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      retire_q <= retire_d;
    end
  end

  regfile_32x32 #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1d     (rs1d),
    .rs2d     (rs2d)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_writeback_regfile
//   Directed bench for writeback_regfile. Each retiring instruction pushes its
//   expected {rd, value} onto a scoreboard queue; when retire pulses, the
//   oldest entry is popped and the register is read back through rs2.
// -----------------------------------------------------------------------------
module tb_writeback_regfile;
  import riscv_pkg::*;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [6:0]  wb_opcode;
  logic [2:0]  wb_funct3;
  logic [4:0]  wb_rd;
  logic [31:0] alu_res;
  logic [31:0] wb_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1d;
  logic [31:0] rs2d;
  logic        retire;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  writeback_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_opcode  (wb_opcode),
    .wb_funct3  (wb_funct3),
    .wb_rd      (wb_rd),
    .alu_res    (alu_res),
    .wb_pc      (wb_pc),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1d       (rs1d),
    .rs2d       (rs2d),
    .retire     (retire)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!wb_ready && n < 50) begin
      step();
      n++;
    end
    check("wait_ready", {31'h0, wb_ready}, 32'h1);
  endtask

  // One accepted transfer; leaves the bench 1 time unit after the accepting edge.
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] pc);
    wait_ready();
    wb_valid  = 1'b1;
    wb_opcode = opc;
    wb_funct3 = f3;
    wb_rd     = rd;
    alu_res   = alu;
    wb_pc     = pc;
    step();
    wb_valid  = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    int   n = 0;
    while (!retire && n < 20) begin
      step();
      n++;
    end
    check({tag, "_retire"}, {31'h0, retire}, 32'h1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      rs2_addr = e.rd;
      #1;
      check(tag, rs2d, e.val);
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [1:0] off, input logic [31:0] data, input logic [31:0] exp);
    exp_t e;
    send(OPC_LOAD, f3, rd, {28'h0004000, 2'b00, off}, 32'h0000_0200);
    check({tag, "_ready_low"}, {31'h0, wb_ready}, 32'h0);
    check({tag, "_no_early_retire"}, {31'h0, retire}, 32'h0);
    step();
    step();
    check({tag, "_still_waiting"}, {31'h0, wb_ready}, 32'h0);
    mem_rdata  = data;
    mem_rvalid = 1'b1;
    e.rd = rd;
    e.val = (rd == 5'd0) ? 32'h0 : exp;
    sb.push_back(e);
    #1;
    check({tag, "_ready_low_on_rvalid"}, {31'h0, wb_ready}, 32'h0);
    step();
    mem_rvalid = 1'b0;
    pop_check(tag);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val);
    exp_t e;
    e.rd  = rd;
    e.val = val;
    sb.push_back(e);
  endtask

  initial begin
    logic [31:0] fwd_exp;
    rst_n      = 1'b0;
    wb_valid   = 1'b0;
    wb_opcode  = '0;
    wb_funct3  = '0;
    wb_rd      = '0;
    alu_res    = '0;
    wb_pc      = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rs1_addr   = '0;
    rs2_addr   = '0;

    // 1. Reset state.
    #2;
    check("reset_retire", {31'h0, retire}, 32'h0);
    #10;
    rst_n = 1'b1;
    step();
    check("reset_ready", {31'h0, wb_ready}, 32'h1);
    check("reset_retire_after", {31'h0, retire}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      check("reset_rs1d", rs1d, 32'h0);
      check("reset_rs2d", rs2d, 32'h0);
    end

    // 2. OP write, single retire pulse, x0 discard.
    push(5'd5, 32'hDEAD_BEEF);
    send(OPC_OP, 3'b000, 5'd5, 32'hDEAD_BEEF, 32'h0000_0000);
    pop_check("op_x5");
    step();
    check("op_retire_once", {31'h0, retire}, 32'h0);
    push(5'd0, 32'h0);
    send(OPC_OP_IMM, 3'b000, 5'd0, 32'hFFFF_FFFF, 32'h0000_0004);
    pop_check("op_x0");

    // Non-writing opcode retires but leaves rd untouched.
    push(5'd5, 32'hDEAD_BEEF);
    send(OPC_STORE, 3'b010, 5'd5, 32'h0BAD_0BAD, 32'h0000_0008);
    pop_check("store_no_write");
    push(5'd6, 32'hABCD_E000);
    send(OPC_LUI, 3'b000, 5'd6, 32'hABCD_E000, 32'h0000_000C);
    pop_check("lui_x6");

    // 3. Link value pc+4, including wrap.
    push(5'd1, 32'h0000_0000);
    send(OPC_JAL, 3'b000, 5'd1, 32'h1111_1111, 32'hFFFF_FFFC);
    pop_check("jal_wrap");
    push(5'd2, 32'h0000_0104);
    send(OPC_JALR, 3'b000, 5'd2, 32'h2222_2222, 32'h0000_0100);
    pop_check("jalr_x2");

    // 4. Loads of each width/sign.
    do_load("lb_b3",   F3_LB,  5'd3,  2'b11, 32'h80AA_BBCC, 32'hFFFF_FF80);
    do_load("lhu_h1",  F3_LHU, 5'd4,  2'b10, 32'h80AA_BBCC, 32'h0000_80AA);
    do_load("lh_h0",   F3_LH,  5'd12, 2'b00, 32'h80AA_BBCC, 32'hFFFF_BBCC);
    do_load("lbu_b1",  F3_LBU, 5'd13, 2'b01, 32'h80AA_BBCC, 32'h0000_00BB);
    do_load("lw_full", F3_LW,  5'd14, 2'b11, 32'h80AA_BBCC, 32'h80AA_BBCC);

    // mem_rvalid while IDLE is ignored.
    step();
    mem_rdata  = 32'h5555_5555;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("idle_rvalid_no_retire", {31'h0, retire}, 32'h0);
    check("idle_rvalid_ready", {31'h0, wb_ready}, 32'h1);
    rs1_addr = 5'd3;
    #1;
    check("idle_rvalid_x3_kept", rs1d, 32'hFFFF_FF80);

    // wb_valid during WAIT_LOAD is not accepted.
    send(OPC_LOAD, F3_LW, 5'd11, 32'h0000_0040, 32'h0000_0300);
    wb_valid  = 1'b1;
    wb_opcode = OPC_OP;
    wb_rd     = 5'd9;
    alu_res   = 32'h0000_0099;
    step();
    step();
    wb_valid = 1'b0;
    check("busy_ready_low", {31'h0, wb_ready}, 32'h0);
    check("busy_no_retire", {31'h0, retire}, 32'h0);
    mem_rdata  = 32'h1234_5678;
    mem_rvalid = 1'b1;
    push(5'd11, 32'h1234_5678);
    step();
    mem_rvalid = 1'b0;
    pop_check("lw_x11");
    step();
    check("busy_retire_once", {31'h0, retire}, 32'h0);
    rs1_addr = 5'd9;
    #1;
    check("busy_x9_unwritten", rs1d, 32'h0);

    // Back-to-back non-load transfers, one per cycle.
    wb_valid  = 1'b1;
    wb_opcode = OPC_OP;
    wb_rd     = 5'd20;
    alu_res   = 32'hA5A5_0001;
    push(5'd20, 32'hA5A5_0001);
    step();
    wb_rd   = 5'd21;
    alu_res = 32'h5A5A_0002;
    push(5'd21, 32'h5A5A_0002);
    pop_check("b2b_first");
    step();
    wb_valid = 1'b0;
    pop_check("b2b_second");

    // 5. Reset while a load is outstanding abandons it.
    send(OPC_LOAD, F3_LW, 5'd10, 32'h0000_0080, 32'h0000_0400);
    check("abandon_wait", {31'h0, wb_ready}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abandon_ready", {31'h0, wb_ready}, 32'h1);
    check("abandon_retire", {31'h0, retire}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    mem_rdata  = 32'hCAFE_F00D;
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("abandon_no_retire", {31'h0, retire}, 32'h0);
    check("abandon_idle", {31'h0, wb_ready}, 32'h1);
    rs1_addr = 5'd10;
    #1;
    check("abandon_x10", rs1d, 32'h0);

    // 6. Same-cycle read of the register being written.
    push(5'd7, 32'h0000_0055);
    send(OPC_OP, 3'b000, 5'd7, 32'h0000_0055, 32'h0000_0500);
    pop_check("fwd_seed_x7");
    rs1_addr  = 5'd7;
    wb_valid  = 1'b1;
    wb_opcode = OPC_OP;
    wb_rd     = 5'd7;
    alu_res   = 32'h0000_1234;
    push(5'd7, 32'h0000_1234);
`ifdef FORWARD_EN
    fwd_exp = 32'h0000_1234;
`else
    fwd_exp = 32'h0000_0055;
`endif
    #1;
    check("same_cycle_rs1d", rs1d, fwd_exp);
    step();
    wb_valid = 1'b0;
    pop_check("fwd_x7");
    check("after_edge_rs1d", rs1d, 32'h0000_1234);

    if (sb.size() != 0) begin
      check("sb_leftover", sb.size(), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
